psum_accum_ctrl: RTL and testbench
==================================

# psum_accum_ctrl

Sequencer for `rel_mem_accumulator`. It sits between the PE array and the psum global buffer (GBF). When the PE array signals a finished psum set, it steps the accumulator through every psum register-file entry and issues one GBF write per entry. It owns the GBF write address and the double-buffer bank select, and flips the bank on convolution end.

## Interface
Parameters:
- `PSUM_RF_ADDR_BITWIDTH`, 2: psum RF address width; RF_DEPTH = 2^PSUM_RF_ADDR_BITWIDTH entries.
- `GBF_ADDR_BITWIDTH`, 5: GBF write address width.
- `DEPTH`, 32: GBF bank depth in words; must be ≤ 2^GBF_ADDR_BITWIDTH.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `pe_psum_finish` in 1: level from the PE array; a rising edge requests one drain.
- `conv_finish` in 1: convolution-end pulse or level; a rising edge requests a bank swap.
- `gbf_w_ready` in 1: GBF accepts the write this cycle.
- `psum_rf_addr` out PSUM_RF_ADDR_BITWIDTH: RF entry being accumulated/written.
- `acc_en` out 1: accumulator adds `psum_out` at `psum_rf_addr` this cycle.
- `psum_gbf_w_en` out 1: GBF write request.
- `psum_gbf_w_addr` out GBF_ADDR_BITWIDTH: GBF write address.
- `psum_gbf_w_num` out 1: active GBF bank.
- `su_add_finish` out 1: one-cycle pulse when a drain completes.
- `busy` out 1: high in any state other than IDLE.
- `gbf_overflow` out 1: sticky error flag.

## Operation
- All outputs, internal counters and flags reset to 0; state resets to IDLE.
- Edge detection: `pe_psum_finish` and `conv_finish` are registered, and a rise is detected as `cur & ~prev`. A held level never retriggers.
- State machine:
  - IDLE: a start rise or a set `start_pend` → ACC, with `psum_rf_addr`=0 and `start_pend` cleared. Else a conv rise or a set `swap_pend` → SWAP.
  - ACC: `acc_en`=1 for exactly one cycle → WR.
  - WR: `psum_gbf_w_en`=1 and is held until `gbf_w_ready`. On acceptance, `psum_gbf_w_addr` advances. If `psum_rf_addr` == RF_DEPTH-1 → FIN; else `psum_rf_addr`+1 → ACC.
  - FIN: `su_add_finish`=1 for one cycle. Then `swap_pend` → SWAP; else `start_pend` → ACC (address 0); else → IDLE.
  - SWAP: toggle `psum_gbf_w_num`, clear `psum_gbf_w_addr` to 0, clear `swap_pend` → IDLE.
- A start rise outside IDLE sets `start_pend` (one deep). Further rises while it is set are dropped.
- A conv rise in any state other than IDLE or SWAP sets `swap_pend`. It is applied only after the current drain finishes; a drain is never split across banks.
- Start rise and conv rise in the same IDLE cycle: the start wins, `swap_pend` is set, and the swap follows that drain.
- Address wrap: an accepted write at DEPTH-1 sets the address to 0. An accepted write at address 0 after a wrap, without an intervening SWAP, sets `gbf_overflow`. `gbf_overflow` is cleared only by reset; the write still issues.
- `psum_gbf_w_addr` and `psum_rf_addr` are stable while `psum_gbf_w_en`=1 && !`gbf_w_ready`.
- Reset mid-drain: everything returns to IDLE and bank 0 immediately; pending flags are lost.

## Timing
- Start rise sampled at edge N → ACC (`acc_en`=1) during cycle N+1.
- `gbf_w_ready` held high: 2 cycles per RF entry. With RF_DEPTH=4 a drain takes 8 cycles, and `su_add_finish` is high in the cycle after the last accepted write.
- Each stall cycle adds exactly one cycle.
- SWAP takes 1 cycle. The new `psum_gbf_w_num` is visible the cycle after SWAP.
- All outputs are registered or decoded from the registered state; there is no combinational path from input to output.

## Structure
- Shared package `psum_ctrl_pkg`: the state enum (IDLE, ACC, WR, FIN, SWAP) and the RF_DEPTH derivation.
- One sub-module, `wrap_counter`: parameterised modulo-DEPTH counter with `inc`, `clr`, `wrapped` flag. Used for `psum_gbf_w_addr` and its overflow tracking.

## Test plan
- Reset, then a `pe_psum_finish` rise with `gbf_w_ready`=1:
  - `psum_rf_addr` sequence is 0,1,2,3.
  - `psum_gbf_w_addr` sequence is 0,1,2,3.
  - `acc_en` and `psum_gbf_w_en` alternate.
  - `su_add_finish` pulses 9 cycles after the rise edge.
  - Holding `pe_psum_finish` high causes no second drain.
- `gbf_w_ready` low for 3 cycles on entry 2 → address 2 is held for 4 cycles and the drain lengthens by 3 cycles.
- `conv_finish` rise during entry 1 → the drain completes on bank 0, then SWAP. `psum_gbf_w_num`=1 and the next drain writes from address 0.
- A second `pe_psum_finish` rise mid-drain → starts immediately after FIN, with no pass through IDLE. A third rise in the same drain is ignored.
- 9 drains with no conv_finish (DEPTH=32) → addresses wrap after 8 drains, and `gbf_overflow`=1 at the first write of drain 9.
- Reset asserted during WR → all outputs 0 asynchronously; `psum_gbf_w_num`=0 after release.

Source files
------------

// File: rtl/psum_ctrl_pkg.sv
// Shared types for the psum accumulation sequencer: controller states and RF depth helper.
package psum_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACC,
        WR,
        FIN,
        SWAP
    } state_t;

    function automatic int unsigned rf_depth(input int unsigned addr_bits);
        return 32'd1 << addr_bits;
    endfunction

endpackage

// File: rtl/psum_accum_ctrl_wrap_counter.sv
// Modulo-DEPTH up counter; 'wrapped' remembers a rollover until the next clear.
module wrap_counter #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             wrapped
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(DEPTH - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            wrapped <= 1'b0;
        end else if (clr) begin
            count   <= '0;
            wrapped <= 1'b0;
        end else if (inc) begin
            if (count == LAST) begin
                count   <= '0;
                wrapped <= 1'b1;
            end else begin
                count <= count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/psum_accum_ctrl.sv
// Drains the psum RF into the GBF one entry at a time and manages the GBF bank swap.
module psum_accum_ctrl
    import psum_ctrl_pkg::*;
#(
    parameter int PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int GBF_ADDR_BITWIDTH     = 5,
    parameter int DEPTH                 = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             pe_psum_finish,
    input  logic                             conv_finish,
    input  logic                             gbf_w_ready,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0] psum_rf_addr,
    output logic                             acc_en,
    output logic                             psum_gbf_w_en,
    output logic [GBF_ADDR_BITWIDTH-1:0]     psum_gbf_w_addr,
    output logic                             psum_gbf_w_num,
    output logic                             su_add_finish,
    output logic                             busy,
    output logic                             gbf_overflow
);

    localparam logic [PSUM_RF_ADDR_BITWIDTH-1:0] RF_LAST =
        PSUM_RF_ADDR_BITWIDTH'(rf_depth(PSUM_RF_ADDR_BITWIDTH) - 1);

    state_t state, next_state;
    logic   pe_cur, pe_prev, conv_cur, conv_prev;
    logic   start_rise, conv_rise;
    logic   start_pend, swap_pend;
    logic   start_drain, write_accept, wrapped;

    assign start_rise   = pe_cur & ~pe_prev;
    assign conv_rise    = conv_cur & ~conv_prev;
    assign write_accept = (state == WR) && gbf_w_ready;

    assign acc_en        = (state == ACC);
    assign psum_gbf_w_en = (state == WR);
    assign su_add_finish = (state == FIN);
    assign busy          = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pe_cur    <= 1'b0;
            pe_prev   <= 1'b0;
            conv_cur  <= 1'b0;
            conv_prev <= 1'b0;
        end else begin
            state     <= next_state;
            pe_cur    <= pe_psum_finish;
            pe_prev   <= pe_cur;
            conv_cur  <= conv_finish;
            conv_prev <= conv_cur;
        end
    end

    // A pending swap always beats a pending start so a drain never straddles banks.
    always_comb begin
        next_state  = state;
        start_drain = 1'b0;
        case (state)
            IDLE: begin
                if (start_rise || start_pend) begin
                    next_state  = ACC;
                    start_drain = 1'b1;
                end else if (conv_rise || swap_pend) begin
                    next_state = SWAP;
                end
            end
            ACC: next_state = WR;
            WR: begin
                if (gbf_w_ready) begin
                    next_state = (psum_rf_addr == RF_LAST) ? FIN : ACC;
                end
            end
            FIN: begin
                if (swap_pend) begin
                    next_state = SWAP;
                end else if (start_pend) begin
                    next_state  = ACC;
                    start_drain = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            SWAP: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_pend <= 1'b0;
            swap_pend  <= 1'b0;
        end else begin
            if (start_drain) begin
                start_pend <= 1'b0;
            end else if (start_rise && state != IDLE) begin
                start_pend <= 1'b1;
            end
            if (state == SWAP) begin
                swap_pend <= 1'b0;
            end else if (conv_rise && (state != IDLE || start_drain)) begin
                swap_pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psum_rf_addr   <= '0;
            psum_gbf_w_num <= 1'b0;
            gbf_overflow   <= 1'b0;
        end else begin
            if (start_drain) begin
                psum_rf_addr <= '0;
            end else if (write_accept && psum_rf_addr != RF_LAST) begin
                psum_rf_addr <= psum_rf_addr + PSUM_RF_ADDR_BITWIDTH'(1);
            end
            if (state == SWAP) begin
                psum_gbf_w_num <= ~psum_gbf_w_num;
            end
            // Landing on address 0 again in the same bank means older psums get overwritten.
            if (write_accept && psum_gbf_w_addr == '0 && wrapped) begin
                gbf_overflow <= 1'b1;
            end
        end
    end

    wrap_counter #(
        .DEPTH (DEPTH),
        .WIDTH (GBF_ADDR_BITWIDTH)
    ) u_gbf_addr (
        .clk     (clk),
        .reset   (reset),
        .inc     (write_accept),
        .clr     (state == SWAP),
        .count   (psum_gbf_w_addr),
        .wrapped (wrapped)
    );

endmodule

// File: tb/tb_psum_accum_ctrl.sv
// Randomised-model plus directed-scenario bench for psum_accum_ctrl.
module tb_psum_accum_ctrl;

    localparam int RF_BITS  = 2;
    localparam int GBF_BITS = 5;
    localparam int DEPTH    = 32;
    localparam int RF_DEPTH = 4;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                pe_psum_finish = 1'b0;
    logic                conv_finish = 1'b0;
    logic                gbf_w_ready = 1'b1;
    logic [RF_BITS-1:0]  psum_rf_addr;
    logic                acc_en;
    logic                psum_gbf_w_en;
    logic [GBF_BITS-1:0] psum_gbf_w_addr;
    logic                psum_gbf_w_num;
    logic                su_add_finish;
    logic                busy;
    logic                gbf_overflow;

    int checks = 0;
    int errors = 0;

    psum_accum_ctrl #(
        .PSUM_RF_ADDR_BITWIDTH (RF_BITS),
        .GBF_ADDR_BITWIDTH     (GBF_BITS),
        .DEPTH                 (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pe_psum_finish  (pe_psum_finish),
        .conv_finish     (conv_finish),
        .gbf_w_ready     (gbf_w_ready),
        .psum_rf_addr    (psum_rf_addr),
        .acc_en          (acc_en),
        .psum_gbf_w_en   (psum_gbf_w_en),
        .psum_gbf_w_addr (psum_gbf_w_addr),
        .psum_gbf_w_num  (psum_gbf_w_num),
        .su_add_finish   (su_add_finish),
        .busy            (busy),
        .gbf_overflow    (gbf_overflow)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: a drain is "entry k, accumulate half or write half"; pending requests are plain flags.
    bit m_pcur, m_pprev, m_ccur, m_cprev;
    bit m_drain, m_write, m_fin, m_swap, m_spend, m_wpend;
    bit m_bank, m_wrapped, m_overflow;
    int m_entry, m_waddr;

    task automatic modelReset();
        {m_pcur, m_pprev, m_ccur, m_cprev} = '0;
        {m_drain, m_write, m_fin, m_swap, m_spend, m_wpend} = '0;
        {m_bank, m_wrapped, m_overflow} = '0;
        m_entry = 0;
        m_waddr = 0;
    endtask

    task automatic beginDrain();
        m_drain = 1'b1;
        m_write = 1'b0;
        m_entry = 0;
        m_spend = 1'b0;
    endtask

    task automatic modelStep();
        bit sr, cr, was_idle, old_spend, old_wpend;
        sr        = m_pcur && !m_pprev;
        cr        = m_ccur && !m_cprev;
        was_idle  = !(m_drain || m_fin || m_swap);
        old_spend = m_spend;
        old_wpend = m_wpend;
        if (!was_idle && sr) m_spend = 1'b1;
        if (cr && !was_idle && !m_swap) m_wpend = 1'b1;
        if (was_idle) begin
            if (sr || old_spend) begin
                beginDrain();
                if (cr) m_wpend = 1'b1;
            end else if (cr || old_wpend) begin
                m_swap = 1'b1;
            end
        end else if (m_drain) begin
            if (!m_write) begin
                m_write = 1'b1;
            end else if (gbf_w_ready) begin
                if (m_waddr == 0 && m_wrapped) m_overflow = 1'b1;
                m_waddr++;
                if (m_waddr == DEPTH) begin
                    m_waddr   = 0;
                    m_wrapped = 1'b1;
                end
                if (m_entry == RF_DEPTH - 1) begin
                    m_drain = 1'b0;
                    m_fin   = 1'b1;
                end else begin
                    m_entry++;
                    m_write = 1'b0;
                end
            end
        end else if (m_fin) begin
            m_fin = 1'b0;
            if (old_wpend) m_swap = 1'b1;
            else if (old_spend) beginDrain();
        end else begin
            m_swap    = 1'b0;
            m_bank    = !m_bank;
            m_waddr   = 0;
            m_wrapped = 1'b0;
            m_wpend   = 1'b0;
        end
        m_pprev = m_pcur;
        m_pcur  = pe_psum_finish;
        m_cprev = m_ccur;
        m_ccur  = conv_finish;
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) modelReset();
            else modelStep();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("cmp_acc_en", acc_en, int'(m_drain && !m_write));
            checkOutput("cmp_w_en", psum_gbf_w_en, int'(m_drain && m_write));
            checkOutput("cmp_rf_addr", psum_rf_addr, m_entry);
            checkOutput("cmp_w_addr", psum_gbf_w_addr, m_waddr);
            checkOutput("cmp_bank", psum_gbf_w_num, int'(m_bank));
            checkOutput("cmp_finish", su_add_finish, int'(m_fin));
            checkOutput("cmp_busy", busy, int'(m_drain || m_fin || m_swap));
            checkOutput("cmp_overflow", gbf_overflow, int'(m_overflow));
        end
    end

    int step;
    int stall_entry = -1;
    int stall_left  = 0;
    int acc_steps[$], acc_rf[$], wr_steps[$], wr_addr[$], wr_bank[$], wen_addr[$], fin_steps[$];
    int obs_bank[$], obs_busy[$], obs_ovf[$];

    function automatic int qAt(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    task automatic clearLogs();
        step = 0;
        acc_steps.delete(); acc_rf.delete(); wr_steps.delete(); wr_addr.delete();
        wr_bank.delete(); wen_addr.delete(); fin_steps.delete();
        obs_bank.delete(); obs_busy.delete(); obs_ovf.delete();
    endtask

    // Observe the cycle's outputs first, then drive inputs for the coming edge.
    task automatic applyStimulus(input bit pe, input bit conv);
        bit rdy;
        @(negedge clk);
        step++;
        rdy = 1'b1;
        if (psum_gbf_w_en && stall_left > 0 && int'(psum_rf_addr) == stall_entry) begin
            rdy = 1'b0;
            stall_left--;
        end
        obs_bank.push_back(psum_gbf_w_num);
        obs_busy.push_back(busy);
        obs_ovf.push_back(gbf_overflow);
        if (acc_en) begin
            acc_steps.push_back(step);
            acc_rf.push_back(psum_rf_addr);
        end
        if (psum_gbf_w_en) begin
            wen_addr.push_back(psum_gbf_w_addr);
            if (rdy) begin
                wr_steps.push_back(step);
                wr_addr.push_back(psum_gbf_w_addr);
                wr_bank.push_back(psum_gbf_w_num);
            end
        end
        if (su_add_finish) fin_steps.push_back(step);
        pe_psum_finish = pe;
        conv_finish    = conv;
        gbf_w_ready    = rdy;
    endtask

    initial begin
        int held;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_acc_en", acc_en, 0);
        checkOutput("rst_w_en", psum_gbf_w_en, 0);
        checkOutput("rst_bank", psum_gbf_w_num, 0);
        checkOutput("rst_overflow", gbf_overflow, 0);
        reset = 1'b0;
        repeat (2) applyStimulus(1'b0, 1'b0);

        // Basic drain with the start level held high throughout.
        clearLogs();
        repeat (17) applyStimulus(1'b1, 1'b0);
        checkOutput("s1_acc_count", acc_rf.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput("s1_rf_addr", qAt(acc_rf, i), i);
            checkOutput("s1_w_addr", qAt(wr_addr, i), i);
            checkOutput("s1_acc_step", qAt(acc_steps, i), 3 + 2 * i);
            checkOutput("s1_wr_step", qAt(wr_steps, i), 4 + 2 * i);
        end
        checkOutput("s1_fin_count", fin_steps.size(), 1);
        checkOutput("s1_fin_delay", qAt(fin_steps, 0) - 2, 9);
        repeat (3) applyStimulus(1'b0, 1'b0);

        // Three-cycle stall on entry 2 (GBF address 6).
        clearLogs();
        stall_entry = 2;
        stall_left  = 3;
        applyStimulus(1'b1, 1'b0);
        repeat (19) applyStimulus(1'b0, 1'b0);
        held = 0;
        foreach (wen_addr[i]) if (wen_addr[i] == 6) held++;
        checkOutput("s2_addr6_hold", held, 4);
        checkOutput("s2_first_addr", qAt(wr_addr, 0), 4);
        checkOutput("s2_last_addr", qAt(wr_addr, 3), 7);
        checkOutput("s2_fin_delay", qAt(fin_steps, 0) - 2, 12);
        stall_entry = -1;

        // conv_finish during entry 1: drain stays on bank 0, then swap.
        clearLogs();
        applyStimulus(1'b1, 1'b0);
        repeat (3) applyStimulus(1'b0, 1'b0);
        repeat (2) applyStimulus(1'b0, 1'b1);
        repeat (10) applyStimulus(1'b0, 1'b0);
        checkOutput("s3_first_addr", qAt(wr_addr, 0), 8);
        checkOutput("s3_last_bank", qAt(wr_bank, 3), 0);
        checkOutput("s3_fin_step", qAt(fin_steps, 0), 11);
        checkOutput("s3_swap_busy", qAt(obs_busy, 11), 1);
        checkOutput("s3_swap_bank_old", qAt(obs_bank, 11), 0);
        checkOutput("s3_bank_new", qAt(obs_bank, 12), 1);
        checkOutput("s3_idle_after", qAt(obs_busy, 12), 0);
        clearLogs();
        applyStimulus(1'b1, 1'b0);
        repeat (12) applyStimulus(1'b0, 1'b0);
        checkOutput("s3_next_bank", qAt(wr_bank, 0), 1);
        checkOutput("s3_next_addr0", qAt(wr_addr, 0), 0);
        checkOutput("s3_next_addr3", qAt(wr_addr, 3), 3);

        // Second rise mid-drain chains straight after FIN; third rise dropped.
        clearLogs();
        for (int s = 1; s <= 30; s++) applyStimulus(s == 1 || s == 4 || s == 7, 1'b0);
        checkOutput("s4_acc_count", acc_steps.size(), 8);
        checkOutput("s4_fin_count", fin_steps.size(), 2);
        checkOutput("s4_fin0", qAt(fin_steps, 0), 11);
        checkOutput("s4_chain_acc", qAt(acc_steps, 4), 12);
        checkOutput("s4_fin1", qAt(fin_steps, 1), 20);
        checkOutput("s4_chain_addr", qAt(wr_addr, 4), 8);

        // Fresh bank, then nine drains without a swap.
        clearLogs();
        applyStimulus(1'b0, 1'b1);
        repeat (4) applyStimulus(1'b0, 1'b0);
        checkOutput("s5_bank_fresh", qAt(obs_bank, 4), 0);
        for (int d = 1; d <= 9; d++) begin
            clearLogs();
            applyStimulus(1'b1, 1'b0);
            repeat (11) applyStimulus(1'b0, 1'b0);
            if (d == 8) begin
                checkOutput("s5_no_ovf_8", qAt(obs_ovf, 11), 0);
                checkOutput("s5_wrapped_addr", psum_gbf_w_addr, 0);
            end
        end
        checkOutput("s5_d9_addr", qAt(wr_addr, 0), 0);
        checkOutput("s5_ovf_before", qAt(obs_ovf, 3), 0);
        checkOutput("s5_ovf_after", qAt(obs_ovf, 4), 1);

        // Asynchronous reset in the middle of a write on bank 1.
        applyStimulus(1'b0, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b0);
        clearLogs();
        applyStimulus(1'b1, 1'b0);
        repeat (5) applyStimulus(1'b0, 1'b0);
        checkOutput("s6_pre_w_en", psum_gbf_w_en, 1);
        checkOutput("s6_pre_rf", psum_rf_addr, 1);
        checkOutput("s6_pre_bank", psum_gbf_w_num, 1);
        #1 reset = 1'b1;
        #1;
        checkOutput("s6_rst_w_en", psum_gbf_w_en, 0);
        checkOutput("s6_rst_rf", psum_rf_addr, 0);
        checkOutput("s6_rst_waddr", psum_gbf_w_addr, 0);
        checkOutput("s6_rst_bank", psum_gbf_w_num, 0);
        checkOutput("s6_rst_busy", busy, 0);
        checkOutput("s6_rst_ovf", gbf_overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0);
        checkOutput("s6_post_bank", psum_gbf_w_num, 0);
        checkOutput("s6_post_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
